instr_fetch: RTL

Instruction fetch unit for the RV32I core. It owns the PC and issues in-order word requests to instruction memory, then buffers the returned instructions for decode/ALU with a valid/ready handshake. It closes the loop on the ALU's branch outcome: BrTaken/BrTarget redirect the PC and squash wrong-path instructions that are already in flight or buffered.

---
 rtl/instr_fetch_pkg.sv | 24 ++
 rtl/instr_fetch_fifo.sv | 65 ++++++
 rtl/instr_fetch.sv | 131 +++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared RV32I core types used by the instruction fetch unit and its buffer.
package Rv32iPkg;

    // Architectural widths of the core; the fetch unit parameters default to these.
    localparam int XLEN        = 32;
    localparam int ILEN        = 32;

    // Every RV32I instruction is one aligned 32-bit word.
    localparam int INSTR_BYTES = 4;

    // Fetch control: one idle boot cycle, normal fetch, and the wrong-path drain.
    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
    } FetchStateT;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [ILEN-1:0] Instr;
        logic [XLEN-1:0] Pc;
    } FetchEntryT;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO of fetched instructions. Flush empties it in one
// cycle and wins over a simultaneous push; push and pop may share a cycle
// even when the FIFO is full.
module fetch_fifo
    import Rv32iPkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     Clk,
    input  logic                     RstN,
    input  logic                     Push,
    input  FetchEntryT               PushData,
    input  logic                     Pop,
    input  logic                     Flush,
    output FetchEntryT               HeadData,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Empty,
    output logic                     Full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    FetchEntryT        mem [DEPTH];
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic              doPush;
    logic              doPop;

    assign Empty    = (Count == '0);
    assign Full     = (Count == CNT_W'(DEPTH));
    assign doPop    = Pop & ~Empty;
    assign doPush   = Push & (~Full | doPop);
    assign HeadData = mem[rdPtr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            rdPtr <= '0;
            wrPtr <= '0;
            Count <= '0;
        end else if (Flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            Count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            Count <= Count + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    // Entry storage.
    // NOTE: the storage is reset on purpose: the head is visible on the outputs
    // while empty, and it must read as zero straight out of reset. Only a couple
    // of entries, so the reset fan-out is negligible.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (doPush && !Flush) begin
            mem[wrPtr] <= PushData;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// RV32I instruction fetch: owns the PC, issues in-order word requests,
// buffers returned instructions for decode and squashes the wrong path
// on a taken branch. Widths must match the Rv32iPkg entry type.
module instr_fetch
    import Rv32iPkg::*;
#(
    parameter int                    DATA_WIDTH  = XLEN,
    parameter int                    INSTR_WIDTH = ILEN,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    FIFO_DEPTH  = 2
) (
    input  logic                   Clk,
    input  logic                   RstN,
    output logic                   ImemReq,
    output logic [DATA_WIDTH-1:0]  ImemAddr,
    input  logic                   ImemGnt,
    input  logic                   ImemRspValid,
    input  logic [INSTR_WIDTH-1:0] ImemRspData,
    input  logic                   BrTaken,
    input  logic [DATA_WIDTH-1:0]  BrTarget,
    output logic                   InstrValid,
    output logic [INSTR_WIDTH-1:0] Instr,
    output logic [DATA_WIDTH-1:0]  InstrPc,
    input  logic                   InstrReady
);

    localparam int                    CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(INSTR_BYTES);

    FetchStateT             state;
    logic [DATA_WIDTH-1:0]  Pc;
    logic [DATA_WIDTH-1:0]  RspPc;
    logic [CNT_W-1:0]       OutCnt;
    logic [CNT_W-1:0]       DropCnt;

    logic [CNT_W-1:0]       fifoCount;
    logic                   fifoEmpty;
    logic                   fifoFull;
    FetchEntryT             pushEntry;
    FetchEntryT             headEntry;

    logic [CNT_W:0]         occupancy;
    logic                   grant;
    logic                   rspPush;
    logic                   popFire;
    logic [DATA_WIDTH-1:0]  brPc;
    logic [CNT_W-1:0]       redirectDrop;
    logic                   unusedBits;

    // Requests in flight plus entries already buffered never exceed the FIFO
    // depth, so every response is guaranteed a slot when it arrives.
    assign occupancy = {1'b0, OutCnt} + {1'b0, fifoCount};
    assign ImemReq   = (state == S_RUN) & ~BrTaken & (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign ImemAddr  = Pc;
    assign grant     = ImemReq & ImemGnt;

    // Responses arriving during a redirect or a drain belong to the wrong path.
    assign rspPush   = ImemRspValid & (state == S_RUN) & ~BrTaken;
    assign popFire   = InstrValid & InstrReady;

    assign brPc         = {BrTarget[DATA_WIDTH-1:2], 2'b00};
    assign redirectDrop = OutCnt + DropCnt - CNT_W'(ImemRspValid);

    assign pushEntry  = '{Instr: ImemRspData, Pc: RspPc};
    assign InstrValid = ~fifoEmpty;
    assign Instr      = headEntry.Instr;
    assign InstrPc    = headEntry.Pc;

    // Target alignment bits are ignored and the buffer never overflows by construction.
    assign unusedBits = ^{BrTarget[1:0], fifoFull};

    // Fetch FSM with the outstanding-request and pending-drop counters.
    // NOTE: state is updated with non-blocking assignments so every register
    // here sees the values from the start of the cycle, regardless of order.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state   <= S_BOOT;
            OutCnt  <= '0;
            DropCnt <= '0;
        end else if (BrTaken) begin
            OutCnt  <= '0;
            DropCnt <= redirectDrop;
            state   <= (redirectDrop != '0) ? S_FLUSH : S_RUN;
        end else begin
            OutCnt <= OutCnt + CNT_W'(grant) - CNT_W'(rspPush);
            unique case (state)
                S_BOOT:  state <= S_RUN;
                S_RUN:   state <= S_RUN;
                S_FLUSH: begin
                    if (ImemRspValid) begin
                        DropCnt <= DropCnt - CNT_W'(1);
                        if (DropCnt == CNT_W'(1)) state <= S_RUN;
                    end else if (DropCnt == '0) begin
                        state <= S_RUN;
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

    // Request PC and the PC tagged onto the next in-order response.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            Pc    <= RESET_PC;
            RspPc <= RESET_PC;
        end else if (BrTaken) begin
            Pc    <= brPc;
            RspPc <= brPc;
        end else begin
            if (grant)   Pc    <= Pc + PC_STEP;
            if (rspPush) RspPc <= RspPc + PC_STEP;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .Clk      (Clk),
        .RstN     (RstN),
        .Push     (rspPush),
        .PushData (pushEntry),
        .Pop      (popFire),
        .Flush    (BrTaken),
        .HeadData (headEntry),
        .Count    (fifoCount),
        .Empty    (fifoEmpty),
        .Full     (fifoFull)
    );

endmodule
